// File: rtl/pc_fetch_unit.sv
// PC register and instruction-fetch sequencer feeding decode.
// Define PC_ALIGN_CHECK_EN to trap misaligned redirects to EXC_VECTOR.
module pc_fetch_unit #(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
    parameter logic [31:0] EXC_VECTOR   = 32'h0000_0180
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        instr_valid,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    output logic [31:0] pc_plus4,
    output logic        misalign_exc
);

    typedef enum logic {
        S_FETCH,
        S_WAIT
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic        pend_q, pend_d;
    logic [31:0] rpc_q, rpc_d;
    logic        valid_q, valid_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] ipc_q, ipc_d;
    logic [31:0] p4_q, p4_d;
    logic        mis_q, mis_d;

    logic        slot_free;
    logic        req;
    logic        ack_fire;
    logic        tgt_mis;
    logic [31:0] tgt;

`ifdef PC_ALIGN_CHECK_EN
    always_comb begin
        tgt_mis = |redirect_pc[1:0];
        tgt     = tgt_mis ? EXC_VECTOR : redirect_pc;
    end
`else
    logic unused_cfg;
    assign unused_cfg = ^{EXC_VECTOR, redirect_pc[1:0]};

    always_comb begin
        tgt_mis = 1'b0;
        tgt     = {redirect_pc[31:2], 2'b00};
    end
`endif

    // Request is gated by rst_n so it drops the instant reset asserts.
    always_comb begin
        slot_free = !valid_q || !stall;
        req       = rst_n && ((state_q == S_WAIT) ||
                              (slot_free && !redirect_valid));
        ack_fire  = req && imem_ack;
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        pend_d  = pend_q;
        rpc_d   = rpc_q;
        valid_d = valid_q;
        instr_d = instr_q;
        ipc_d   = ipc_q;
        p4_d    = p4_q;
        mis_d   = 1'b0;
        if (redirect_valid) begin
            valid_d = 1'b0;
            mis_d   = tgt_mis;
            if (state_q == S_WAIT && !imem_ack) begin
                pend_d = 1'b1;
                rpc_d  = tgt;
            end else begin
                pc_d    = tgt;
                pend_d  = 1'b0;
                state_d = S_FETCH;
            end
        end else if (ack_fire) begin
            state_d = S_FETCH;
            if (pend_q) begin
                pc_d   = rpc_q;
                pend_d = 1'b0;
                if (!stall) valid_d = 1'b0;
            end else begin
                instr_d = imem_rdata;
                ipc_d   = pc_q;
                p4_d    = pc_q + 32'd4;
                valid_d = 1'b1;
                pc_d    = pc_q + 32'd4;
            end
        end else begin
            if (req) state_d = S_WAIT;
            if (!stall) valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_FETCH;
            pc_q    <= RESET_VECTOR;
            pend_q  <= 1'b0;
            rpc_q   <= 32'h0;
            valid_q <= 1'b0;
            instr_q <= 32'h0;
            ipc_q   <= 32'h0;
            p4_q    <= 32'h0;
            mis_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            pend_q  <= pend_d;
            rpc_q   <= rpc_d;
            valid_q <= valid_d;
            instr_q <= instr_d;
            ipc_q   <= ipc_d;
            p4_q    <= p4_d;
            mis_q   <= mis_d;
        end
    end

    assign imem_req     = req;
    assign imem_addr    = pc_q;
    assign instr_valid  = valid_q;
    assign instr        = instr_q;
    assign instr_pc     = ipc_q;
    assign pc_plus4     = p4_q;
    assign misalign_exc = mis_q;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Randomized bench for pc_fetch_unit against a transaction-level model.
// Second instance checks PC wrap from a 0xFFFF_FFFC reset vector.
module tb_pc_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic [31:0] pc_plus4;
    logic        misalign_exc;

    logic        w_req;
    logic [31:0] w_addr;
    logic        w_valid;
    logic [31:0] w_instr;
    logic [31:0] w_ipc;
    logic [31:0] w_p4;
    logic        w_mis;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    pc_fetch_unit u_dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .stall          (stall),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_ack       (imem_ack),
        .imem_rdata     (imem_rdata),
        .instr_valid    (instr_valid),
        .instr          (instr),
        .instr_pc       (instr_pc),
        .pc_plus4       (pc_plus4),
        .misalign_exc   (misalign_exc)
    );

    pc_fetch_unit #(.RESET_VECTOR(32'hFFFF_FFFC)) u_wrap (
        .clk            (clk),
        .rst_n          (rst_n),
        .stall          (1'b0),
        .redirect_valid (1'b0),
        .redirect_pc    (32'h0),
        .imem_req       (w_req),
        .imem_addr      (w_addr),
        .imem_ack       (w_req),
        .imem_rdata     (32'h0000_0013),
        .instr_valid    (w_valid),
        .instr          (w_instr),
        .instr_pc       (w_ipc),
        .pc_plus4       (w_p4),
        .misalign_exc   (w_mis)
    );

    // Reference model: architectural view of the fetch stream.
    logic        m_valid;
    logic [31:0] m_instr, m_ipc, m_p4;
    logic        m_mis;
    logic [31:0] m_next;
    logic        m_out;
    logic [31:0] m_oaddr;
    logic        m_pend;
    logic [31:0] m_ptgt;

    function automatic logic [31:0] memf(input logic [31:0] a);
        return (a * 32'h9E37_79B9) ^ 32'h5A5A_0013;
    endfunction

    function automatic logic [32:0] eff(input logic [31:0] rp);
`ifdef PC_ALIGN_CHECK_EN
        if (rp[1:0] != 2'b00) return {1'b1, 32'h0000_0180};
        return {1'b0, rp};
`else
        return {1'b0, rp & 32'hFFFF_FFFC};
`endif
    endfunction

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_valid = 0; m_instr = 0; m_ipc = 0; m_p4 = 0; m_mis = 0;
        m_next = 32'h0; m_out = 0; m_oaddr = 0; m_pend = 0; m_ptgt = 0;
    endtask

    // One cycle; entered and left at a falling edge.
    task automatic step(input int ps, input int pr, input int pa,
                        input bit frd, input logic [31:0] frpc);
        logic        ereq;
        logic [31:0] eaddr;
        logic        ack;
        logic [32:0] e;
        logic [31:0] rp;
        chk("valid", {31'h0, instr_valid}, {31'h0, m_valid});
        if (m_valid) begin
            chk("instr", instr, m_instr);
            chk("instr_pc", instr_pc, m_ipc);
            chk("pc_plus4", pc_plus4, m_p4);
        end
        chk("misalign", {31'h0, misalign_exc}, {31'h0, m_mis});
        rp = $urandom & 32'h0000_0FFC;
        if ($urandom_range(3) == 0) rp[1:0] = 2'($urandom_range(3));
        stall          = ($urandom_range(99) < ps);
        redirect_valid = frd || ($urandom_range(99) < pr);
        redirect_pc    = frd ? frpc : rp;
        #1;
        ereq  = m_out || ((!m_valid || !stall) && !redirect_valid);
        eaddr = m_out ? m_oaddr : m_next;
        chk("req", {31'h0, imem_req}, {31'h0, ereq});
        if (ereq) chk("addr", imem_addr, eaddr);
        ack        = ereq && ($urandom_range(99) < pa);
        imem_ack   = ack;
        imem_rdata = ack ? memf(imem_addr) : $urandom;
        m_mis = 0;
        if (redirect_valid) begin
            e = eff(redirect_pc);
            m_mis   = e[32];
            m_valid = 0;
            if (m_out && !ack) begin
                m_pend = 1;
                m_ptgt = e[31:0];
            end else begin
                m_next = e[31:0];
                m_pend = 0;
                m_out  = 0;
            end
        end else if (ereq && ack) begin
            m_out = 0;
            if (m_pend) begin
                m_next = m_ptgt;
                m_pend = 0;
                if (!stall) m_valid = 0;
            end else begin
                m_valid = 1;
                m_instr = memf(eaddr);
                m_ipc   = eaddr;
                m_p4    = eaddr + 32'd4;
                m_next  = eaddr + 32'd4;
            end
        end else begin
            if (ereq) begin
                m_out   = 1;
                m_oaddr = eaddr;
            end
            if (!stall) m_valid = 0;
        end
        @(negedge clk);
    endtask

    initial begin
        rst_n = 0; stall = 0; redirect_valid = 0; redirect_pc = 0;
        imem_ack = 0; imem_rdata = 0;
        model_reset();
        repeat (2) @(negedge clk);
        chk("rst_req", {31'h0, imem_req}, 32'h0);
        chk("rst_addr", imem_addr, 32'h0);
        chk("rst_valid", {31'h0, instr_valid}, 32'h0);
        chk("rst_instr", instr, 32'h0);
        chk("rst_ipc", instr_pc, 32'h0);
        chk("rst_p4", pc_plus4, 32'h0);
        chk("rst_mis", {31'h0, misalign_exc}, 32'h0);
        rst_n = 1;
        #1;
        chk("wrap_addr0", w_addr, 32'hFFFF_FFFC);
        #1;
        // 0-wait memory, no stall: one fetch per cycle
        step(0, 0, 100, 0, 0);
        chk("wrap_addr1", w_addr, 32'h0);
        chk("wrap_ipc", w_ipc, 32'hFFFF_FFFC);
        chk("wrap_p4", w_p4, 32'h0);
        repeat (6) step(0, 0, 100, 0, 0);
        // slow memory, then misaligned redirect while waiting
        repeat (3) step(0, 0, 0, 0, 0);
        step(0, 0, 0, 1, 32'h0000_0042);
        step(0, 0, 100, 0, 0);
        repeat (4) step(0, 0, 100, 0, 0);
        // aligned redirect mid-wait
        repeat (2) step(0, 0, 0, 0, 0);
        step(0, 0, 0, 1, 32'h0000_0040);
        repeat (4) step(0, 0, 100, 0, 0);
        // stall holds the slot
        repeat (3) step(100, 0, 100, 0, 0);
        repeat (3) step(0, 0, 100, 0, 0);
        // random mix
        repeat (400) step(30, 8, 50, 0, 0);
        repeat (400) step(10, 3, 100, 0, 0);
        // reset asserted while a request is outstanding
        step(0, 0, 0, 0, 0);
        chk("pre_rst_out", {31'h0, imem_req}, 32'h1);
        #1;
        rst_n = 0;
        #1;
        chk("async_req", {31'h0, imem_req}, 32'h0);
        chk("async_addr", imem_addr, 32'h0);
        chk("async_valid", {31'h0, instr_valid}, 32'h0);
        imem_ack = 0;
        @(negedge clk);
        rst_n = 1;
        model_reset();
        repeat (200) step(20, 5, 60, 0, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule
